clk_div_multi: RTL and testbench

Parametrised multi-channel clock divider generating NUM_CH independent square-wave clock enables/outputs from one system clock. Each channel has a programmable half-period, a per-channel enable, a glitch-free shadowed reload of its divide value, and a one-cycle rising-edge tick. A global sync input phase-aligns all channels. It sits between the board clock and the tone, LED-rate and sampling logic, and replaces single-channel free-running dividers.

---
 rtl/clk_div_multi_if.sv | 24 ++
 rtl/clk_div_multi.sv | 109 ++++++++++
 tb/tb_clk_div_multi.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi.
// Master drives divide values and strobes; slave returns clocks and ticks.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH*CNT_W-1:0] div_count;
  logic [NUM_CH-1:0]       update;
  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic [NUM_CH-1:0]       outclk;
  logic [NUM_CH-1:0]       rise_tick;
  logic [NUM_CH-1:0]       pend;

  modport master (
    output div_count, update, en, sync,
    input  outclk, rise_tick, pend
  );

  modport slave (
    input  div_count, update, en, sync,
    output outclk, rise_tick, pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel square-wave divider with shadowed half-period reload.
// Each channel toggles outclk every hp cycles; sync restarts all in phase.
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic             inclk,
  input  logic             Reset,
  clk_div_multi_if.slave   bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  hp_q  [NUM_CH];
  logic [CNT_W-1:0]  hp_d  [NUM_CH];
  logic [CNT_W-1:0]  pv_q  [NUM_CH];
  logic [CNT_W-1:0]  pv_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  always_comb begin
    logic [CNT_W-1:0] hpm1;
    logic [CNT_W-1:0] din;
    logic             idle;
    logic             cont;
    logic             wrap;
    logic             apply;
    cnt_d  = cnt_q;
    hp_d   = hp_q;
    pv_d   = pv_q;
    pend_d = pend_q;
    out_d  = out_q;
    tick_d = '0;
    hpm1   = '0;
    din    = '0;
    idle   = 1'b0;
    cont   = 1'b0;
    wrap   = 1'b0;
    apply  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      hpm1  = hp_q[c] - ONE;
      din   = bus.div_count[c*CNT_W +: CNT_W];
      idle  = !bus.en[c] || (hp_q[c] == '0) || bus.sync;
      cont  = !idle && (cnt_q[c] < hpm1);
      wrap  = !idle && !(cnt_q[c] < hpm1);
      apply = idle || wrap;

      unique case (1'b1)
        idle: begin
          cnt_d[c] = '0;
          out_d[c] = 1'b0;
        end
        cont: begin
          cnt_d[c] = cnt_q[c] + ONE;
        end
        wrap: begin
          cnt_d[c]  = '0;
          out_d[c]  = !out_q[c];
          tick_d[c] = !out_q[c];
        end
        default: ;
      endcase

      // A fresh strobe on an apply point bypasses the shadow register
      if (bus.update[c]) begin
        if (apply) begin
          hp_d[c]   = din;
          pend_d[c] = 1'b0;
        end else begin
          pv_d[c]   = din;
          pend_d[c] = 1'b1;
        end
      end else if (apply && pend_q[c]) begin
        hp_d[c]   = pv_q[c];
        pend_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge inclk) begin
    if (Reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        hp_q[c]  <= '0;
        pv_q[c]  <= '0;
      end
      pend_q <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        hp_q[c]  <= hp_d[c];
        pv_q[c]  <= pv_d[c];
      end
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign bus.outclk    = out_q;
  assign bus.rise_tick = tick_q;
  assign bus.pend      = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi.
// Inputs change 1 time unit after posedge; outputs checked at the same point.
module tb_clk_div_multi;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  clk_div_multi_if #(.NUM_CH(4), .CNT_W(32)) bus ();

  clk_div_multi #(.NUM_CH(4), .CNT_W(32)) dut (
    .inclk (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setdiv(input int c, input logic [31:0] v);
    bus.div_count[c*32 +: 32] = v;
  endtask

  initial begin
    rst           = 1'b1;
    bus.div_count = '0;
    bus.update    = '0;
    bus.en        = '0;
    bus.sync      = 1'b0;
    step(2);
    chk("rst_out",  {28'd0, bus.outclk},    32'h0);
    chk("rst_tick", {28'd0, bus.rise_tick}, 32'h0);
    chk("rst_pend", {28'd0, bus.pend},      32'h0);
    rst = 1'b0;

    // ch0 hp=5 from halted: immediate apply
    setdiv(0, 5);
    bus.update = 4'b0001;
    step(1);
    bus.update = '0;
    chk("t1_pend", bus.pend[0], 1'b0);
    bus.en[0] = 1'b1;
    step(4);
    chk("t1_pre_rise", bus.outclk[0], 1'b0);
    step(1);
    chk("t1_rise", bus.outclk[0], 1'b1);
    chk("t1_tick", bus.rise_tick[0], 1'b1);
    step(1);
    chk("t1_tick_1w", bus.rise_tick[0], 1'b0);
    step(4);
    chk("t1_fall", bus.outclk[0], 1'b0);
    chk("t1_fall_notick", bus.rise_tick[0], 1'b0);
    step(5);
    chk("t1_rise2", bus.outclk[0], 1'b1);
    chk("t1_tick2", bus.rise_tick[0], 1'b1);
    bus.en[0] = 1'b0;
    step(1);
    chk("t1_dis_out", bus.outclk[0], 1'b0);
    chk("t1_dis_tick", bus.rise_tick[0], 1'b0);

    // ch1 hp=3, reload 7 mid high phase
    setdiv(1, 3);
    bus.update = 4'b0010;
    step(1);
    bus.update = '0;
    bus.en[1]  = 1'b1;
    step(3);
    chk("t2_rise", bus.outclk[1], 1'b1);
    step(1);
    setdiv(1, 7);
    bus.update = 4'b0010;
    step(1);
    bus.update = '0;
    chk("t2_pend_set", bus.pend[1], 1'b1);
    chk("t2_still_hi", bus.outclk[1], 1'b1);
    step(1);
    chk("t2_fall", bus.outclk[1], 1'b0);
    chk("t2_pend_clr", bus.pend[1], 1'b0);
    step(6);
    chk("t2_low7", bus.outclk[1], 1'b0);
    step(1);
    chk("t2_rise7", bus.outclk[1], 1'b1);
    chk("t2_tick7", bus.rise_tick[1], 1'b1);
    bus.en[1] = 1'b0;
    step(1);

    // all channels hp=4, staggered enables, then sync
    for (int c = 0; c < 4; c++) setdiv(c, 4);
    bus.update = 4'b1111;
    step(1);
    bus.update = '0;
    chk("t3_pend", {28'd0, bus.pend}, 32'h0);
    bus.en = 4'b0001; step(1);
    bus.en = 4'b0011; step(1);
    bus.en = 4'b0111; step(1);
    bus.en = 4'b1111; step(2);
    bus.sync = 1'b1;
    step(1);
    bus.sync = 1'b0;
    chk("t3_sync_out",  {28'd0, bus.outclk},    32'h0);
    chk("t3_sync_tick", {28'd0, bus.rise_tick}, 32'h0);
    step(3);
    chk("t3_pre", {28'd0, bus.outclk}, 32'h0);
    step(1);
    chk("t3_rise", {28'd0, bus.outclk},    32'hf);
    chk("t3_tick", {28'd0, bus.rise_tick}, 32'hf);
    bus.en = '0;
    step(1);

    // ch2 hp=1: inclk/2, then reload 0 halts it
    setdiv(2, 1);
    bus.update = 4'b0100;
    step(1);
    bus.update = '0;
    bus.en[2]  = 1'b1;
    step(1);
    chk("t4_hi",   bus.outclk[2],    1'b1);
    chk("t4_tick", bus.rise_tick[2], 1'b1);
    step(1);
    chk("t4_lo",    bus.outclk[2],    1'b0);
    chk("t4_notick", bus.rise_tick[2], 1'b0);
    step(1);
    chk("t4_hi2",   bus.outclk[2],    1'b1);
    chk("t4_tick2", bus.rise_tick[2], 1'b1);
    setdiv(2, 0);
    bus.update = 4'b0100;
    step(1);
    bus.update = '0;
    chk("t4_zero_out",  bus.outclk[2], 1'b0);
    chk("t4_zero_pend", bus.pend[2],   1'b0);
    step(3);
    chk("t4_held_out",  bus.outclk[2],    1'b0);
    chk("t4_held_tick", bus.rise_tick[2], 1'b0);
    bus.en[2] = 1'b0;
    step(1);

    // Reset mid high phase on ch0 (hp=5, pending 9)
    bus.en[0] = 1'b1;
    step(5);
    chk("t5_rise", bus.outclk[0], 1'b1);
    setdiv(0, 9);
    bus.update = 4'b0001;
    step(1);
    bus.update = '0;
    step(1);
    chk("t5_pre_pend", bus.pend[0],   1'b1);
    chk("t5_pre_out",  bus.outclk[0], 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rst_out",  {28'd0, bus.outclk},    32'h0);
    chk("t5_rst_pend", {28'd0, bus.pend},      32'h0);
    chk("t5_rst_tick", {28'd0, bus.rise_tick}, 32'h0);
    step(8);
    chk("t5_halted", bus.outclk[0], 1'b0);
    bus.en[0] = 1'b0;
    step(1);

    // update+sync+en same cycle on ch3
    setdiv(3, 6);
    bus.update = 4'b1000;
    bus.sync   = 1'b1;
    bus.en[3]  = 1'b1;
    step(1);
    bus.update = '0;
    bus.sync   = 1'b0;
    chk("t6_pend", bus.pend[3],   1'b0);
    chk("t6_out0", bus.outclk[3], 1'b0);
    step(5);
    chk("t6_pre", bus.outclk[3], 1'b0);
    step(1);
    chk("t6_rise", bus.outclk[3],    1'b1);
    chk("t6_tick", bus.rise_tick[3], 1'b1);
    bus.en[3] = 1'b0;
    step(1);
    chk("t6_dis", bus.outclk[3], 1'b0);
    setdiv(3, 6);
    bus.update = 4'b1000;
    bus.sync   = 1'b1;
    step(1);
    bus.update = '0;
    bus.sync   = 1'b0;
    chk("t6b_pend", bus.pend[3], 1'b0);
    step(10);
    chk("t6b_out",  bus.outclk[3],    1'b0);
    chk("t6b_tick", bus.rise_tick[3], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
